shared_sop_approx_adder: RTL and testbench

Parametrised, pipelined approximate adder built from a shared sum-of-products (SOP) network. Product literals and per-output product activations sit in runtime-writable configuration registers, so one instance can host any SOP1-shared-logic approximation of a W-bit adder. A streaming valid/ready datapath evaluates the SOP. An optional exact-reference monitor measures the error of each result against threshold ET. The block sits after the approximation search flow as the hardware-in-the-loop evaluator for candidate circuits.

---
 rtl/shared_sop_approx_adder.sv | 211 +++++++++++++++++++++
 tb/tb_shared_sop_approx_adder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_sop_approx_adder.sv
// shared_sop_approx_adder
//
// Pipelined approximate W-bit adder evaluated by a shared sum-of-products
// network whose product literals (POS/NEG) and per-output activations (ACT)
// live in runtime-writable configuration registers. An optional exact-reference
// monitor reports |approx - exact| per result and counts results whose error
// exceeds ET.
//
// Optional feature macro: SOP_ERR_MONITOR_EN
//   defined   -> exact adder, error magnitude, threshold flag and err_count built
//   undefined -> out_err_abs/out_err_flag/err_count tied to 0, clr_count ignored
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_we/addr/wdata configuration write port (POS at 2p, NEG at 2p+1,
//                     ACT[o] at 2P+o); out-of-range addresses ignored
//   in_valid/ready    operand handshake, in_a/in_b operands
//   out_valid/ready   result handshake
//   out_sum           approximate sum (W+1 bits)
//   out_err_abs       |out_sum - (a+b)|
//   out_err_flag      out_err_abs > ET
//   err_count         saturating count of flagged results accepted downstream
//   clr_count         synchronous clear of err_count (wins over increment)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1. Valid, once raised, holds with stable data until the transfer; ready may
// depend combinationally on the downstream ready but never on in_valid.

module shared_sop_approx_adder #(
  parameter int          W  = 2,
  parameter int          P  = 2,
  parameter int unsigned ET = 3,
  localparam int         CW = (2 * W > P) ? 2 * W : P,
  localparam int         AW = $clog2(2 * P + W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [CW-1:0] cfg_wdata,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W:0]    out_sum,
  output logic [W:0]    out_err_abs,
  output logic          out_err_flag,
  output logic [15:0]   err_count,
  input  logic          clr_count
);

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  logic [2*W-1:0] pos_q [P];
  logic [2*W-1:0] neg_q [P];
  logic [P-1:0]   act_q [W+1];
  logic [31:0]    addr_ext;

  assign addr_ext = 32'(cfg_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < P; p++) begin
        pos_q[p] <= '0;
        neg_q[p] <= '0;
      end
      for (int o = 0; o <= W; o++) begin
        act_q[o] <= '0;
      end
    end else if (cfg_we) begin
      for (int p = 0; p < P; p++) begin
        if (addr_ext == 32'(2 * p))     pos_q[p] <= cfg_wdata[2*W-1:0];
        if (addr_ext == 32'(2 * p + 1)) neg_q[p] <= cfg_wdata[2*W-1:0];
      end
      for (int o = 0; o <= W; o++) begin
        if (addr_ext == 32'(2 * P + o)) act_q[o] <= cfg_wdata[P-1:0];
      end
    end
  end

  // Upper write-data bits beyond a register's width are don't-care.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfg_wdata;

  // ---------------------------------------------------------------------------
  // Shared SOP network
  // ---------------------------------------------------------------------------
  logic [2*W-1:0] x;
  logic [P-1:0]   pr;
  logic [W:0]     sop_sum;

  assign x = {in_b, in_a};

  // A literal bit that is neither in POS nor NEG contributes 1; a bit in both
  // forces x & ~x = 0, so contradictory products evaluate to 0.
  always_comb begin
    pr      = '0;
    sop_sum = '0;
    for (int p = 0; p < P; p++) begin
      pr[p] = &((x | ~pos_q[p]) & (~x | ~neg_q[p]));
    end
    for (int o = 0; o <= W; o++) begin
      sop_sum[o] = |(pr & act_q[o]);
    end
  end

  // ---------------------------------------------------------------------------
  // Two-stage pipeline
  // ---------------------------------------------------------------------------
  logic       s1_v;
  logic       s2_v;
  logic [W:0] s1_sum;
  logic [W:0] s2_sum;
  logic       s2_en;
  logic       in_fire;

  assign s2_en    = !s2_v || out_ready;
  assign in_ready = !s1_v || s2_en;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_sum <= '0;
    end else if (in_fire) begin
      s1_v   <= 1'b1;
      s1_sum <= sop_sum;
    end else if (s2_en) begin
      s1_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v   <= 1'b0;
      s2_sum <= '0;
    end else if (s2_en) begin
      s2_v <= s1_v;
      if (s1_v) s2_sum <= s1_sum;
    end
  end

  assign out_valid = s2_v;
  assign out_sum   = s2_sum;

  // ---------------------------------------------------------------------------
  // Exact-reference error monitor
  // ---------------------------------------------------------------------------
`ifdef SOP_ERR_MONITOR_EN
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;
  logic [W:0]   exact_n;
  logic [W:0]   err_n;
  logic         flag_n;
  logic [W:0]   s2_err;
  logic         s2_flag;
  logic [15:0]  cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a <= '0;
      s1_b <= '0;
    end else if (in_fire) begin
      s1_a <= in_a;
      s1_b <= in_b;
    end
  end

  // W+1 bits always hold a+b, so the exact sum cannot overflow.
  always_comb begin
    exact_n = {1'b0, s1_a} + {1'b0, s1_b};
    err_n   = (s1_sum >= exact_n) ? (s1_sum - exact_n) : (exact_n - s1_sum);
    flag_n  = 32'(err_n) > 32'(ET);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_err  <= '0;
      s2_flag <= 1'b0;
    end else if (s2_en && s1_v) begin
      s2_err  <= err_n;
      s2_flag <= flag_n;
    end
  end

  // Clear takes priority over a simultaneous flagged handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_count) begin
      cnt_q <= '0;
    end else if (s2_v && out_ready && s2_flag && (cnt_q != 16'hffff)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign out_err_abs  = s2_err;
  assign out_err_flag = s2_flag;
  assign err_count    = cnt_q;
`else
  logic unused_clr;
  assign unused_clr   = clr_count;
  assign out_err_abs  = '0;
  assign out_err_flag = 1'b0;
  assign err_count    = '0;
`endif

endmodule

// File: tb/tb_shared_sop_approx_adder.sv
// Bench for shared_sop_approx_adder (W=2, P=2, ET=3). Directed vectors with
// hand-computed results are pushed into an expected queue by the driver; a
// monitor on the falling edge pops and compares every accepted output, and
// tracks the expected err_count cycle by cycle.

module tb_shared_sop_approx_adder;

  localparam int W  = 2;
  localparam int P  = 2;
  localparam int ET = 3;
  localparam int CW = 4;
  localparam int AW = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          rst_n;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [CW-1:0] cfg_wdata;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    out_sum;
  logic [W:0]    out_err_abs;
  logic          out_err_flag;
  logic [15:0]   err_count;
  logic          clr_count;

  int cyc;
  int total;
  int bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  shared_sop_approx_adder #(.W(W), .P(P), .ET(ET)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_err_abs  (out_err_abs),
    .out_err_flag (out_err_flag),
    .err_count    (err_count),
    .clr_count    (clr_count)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state: {sum[2:0], err[2:0], flag}
  // ---------------------------------------------------------------------------
  logic [6:0] exp_q[$];
  int         t_q[$];
  bit         chk_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [1:0] a, input logic [1:0] b, input logic [2:0] s,
                      input logic [2:0] e, input logic f, input bit lat_chk);
    bit hs;
    int n;
`ifndef SOP_ERR_MONITOR_EN
    e = '0;
    f = 1'b0;
`endif
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    exp_q.push_back({s, e, f});
    t_q.push_back(cyc);
    chk_q.push_back(lat_chk);
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!hs) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic cfg_write(input logic [AW-1:0] addr, input logic [CW-1:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic [15:0] exp_cnt;
  logic        hold;
  logic [W:0]  held_sum;
  logic [6:0]  ex;
  int          t_iss;
  bit          lat_on;
  bit          inc;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_cnt = '0;
      hold    = 1'b0;
    end else begin
      check("err_count", 32'(err_count), 32'(exp_cnt));
      if (hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_sum", 32'(out_sum), 32'(held_sum));
      end
      inc = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(out_sum), 32'hdead);
        end else begin
          ex     = exp_q.pop_front();
          t_iss  = t_q.pop_front();
          lat_on = chk_q.pop_front();
          check("out_sum", 32'(out_sum), 32'(ex[6:4]));
          check("out_err_abs", 32'(out_err_abs), 32'(ex[3:1]));
          check("out_err_flag", 32'(out_err_flag), 32'(ex[0]));
          if (lat_on) check("latency", 32'(cyc - t_iss), 32'd2);
          inc = ex[0];
        end
      end
`ifdef SOP_ERR_MONITOR_EN
      if (clr_count) exp_cnt = '0;
      else if (inc && exp_cnt != 16'hffff) exp_cnt = exp_cnt + 16'd1;
`endif
      hold     = out_valid && !out_ready;
      held_sum = out_sum;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // Programmed configuration: sum = a[0] ? 3'd4 : 3'd3
  logic [1:0] st_a [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0};
  logic [1:0] st_b [6] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd1};
  logic [2:0] st_s [6] = '{3'd3, 3'd4, 3'd3, 3'd4, 3'd4, 3'd3};
  logic [2:0] st_e [6] = '{3'd3, 3'd2, 3'd0, 3'd1, 3'd1, 3'd2};

  initial begin
    total     = 0;
    bad       = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    clr_count = 1'b0;

    // Reset values
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_err_abs", 32'(out_err_abs), 32'd0);
    check("rst_err_flag", 32'(out_err_flag), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset configuration: sum 0, err 6, flagged
    send(2'd3, 2'd3, 3'd0, 3'd6, 1'b1, 1'b1);
    drain();
    @(posedge clk);
    #1;
`ifdef SOP_ERR_MONITOR_EN
    check("cnt_after_first", 32'(err_count), 32'd1);
`else
    check("cnt_after_first", 32'(err_count), 32'd0);
`endif

    // Saturation: clear, then 65538 flagged results
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
    for (int i = 0; i < 65538; i++) send(2'd3, 2'd3, 3'd0, 3'd6, 1'b1, 1'b1);
    drain();
    @(posedge clk);
    #1;
`ifdef SOP_ERR_MONITOR_EN
    check("cnt_saturated", 32'(err_count), 32'hffff);
`else
    check("cnt_saturated", 32'(err_count), 32'd0);
`endif

    // Clear in the same cycle as a flagged handshake
    out_ready = 1'b0;
    send(2'd2, 2'd3, 3'd0, 3'd5, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
    check("clr_wins", 32'(err_count), 32'd0);
    drain();

    // Programmed configuration: pr0 = a0, pr1 = ~a0; sum = {a0, ~a0, ~a0}
    cfg_write(3'd0, 4'b0001);
    cfg_write(3'd3, 4'b0001);
    cfg_write(3'd4, 4'b0010);
    cfg_write(3'd5, 4'b0010);
    cfg_write(3'd6, 4'b0001);
    send(2'd1, 2'd0, 3'd4, 3'd3, 1'b0, 1'b1);
    send(2'd0, 2'd3, 3'd3, 3'd0, 1'b0, 1'b1);
    send(2'd2, 2'd2, 3'd3, 3'd1, 1'b0, 1'b1);
    send(2'd3, 2'd3, 3'd4, 3'd2, 1'b0, 1'b1);
    drain();

    // Write on the capture edge uses old ACT[2]; next input sees ACT[2]=0
    fork
      cfg_write(3'd6, 4'b0000);
      send(2'd3, 2'd3, 3'd4, 3'd2, 1'b0, 1'b1);
    join
    send(2'd1, 2'd0, 3'd0, 3'd1, 1'b0, 1'b1);
    cfg_write(3'd6, 4'b0001);
    cfg_write(3'd7, 4'b1111);   // out of range, must not disturb anything
    send(2'd1, 2'd0, 3'd4, 3'd3, 1'b0, 1'b1);
    drain();

    // Back-to-back stream, 1 per cycle, latency 2
    for (int i = 0; i < 6; i++) send(st_a[i], st_b[i], st_s[i], st_e[i], 1'b0, 1'b1);
    drain();

    // Stream with out_ready low for 3 cycles mid-stream
    fork
      for (int i = 0; i < 6; i++) send(st_a[i], st_b[i], st_s[i], st_e[i], 1'b0, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Pipeline absorbs exactly 2, then in_ready drops; recovers with out_ready
    out_ready = 1'b0;
    send(2'd3, 2'd3, 3'd4, 3'd2, 1'b0, 1'b0);
    send(2'd0, 2'd0, 3'd3, 3'd3, 1'b0, 1'b0);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    check("resume_in_ready", 32'(in_ready), 32'd1);
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send(2'd1, 2'd1, 3'd4, 3'd2, 1'b0, 1'b0);
    send(2'd2, 2'd0, 3'd3, 3'd1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_sum", 32'(out_sum), 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    exp_q.delete();
    t_q.delete();
    chk_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2'd3, 2'd3, 3'd0, 3'd6, 1'b1, 1'b1);
    drain();
    @(posedge clk);
    #1;

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
